// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter fed by a small circular FIFO; queued bytes leave back-to-back.
// Tx is driven from a register so the line never glitches between bit periods.
module uart_transmitter #(
    parameter int CLK_PER_BIT     = 104,
    parameter int COUNTER_WIDTH   = 7,
    parameter int FIFO_ADDR_WIDTH = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       write,
    output logic       Tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       byte_sent,
    output logic [1:0] state_dbg
);

    localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
    localparam logic [COUNTER_WIDTH-1:0]   CNT_MAX    = COUNTER_WIDTH'(CLK_PER_BIT - 1);
    localparam logic [COUNTER_WIDTH-1:0]   CNT_PRE    = COUNTER_WIDTH'(CLK_PER_BIT - 2);
    localparam logic [FIFO_ADDR_WIDTH:0]   COUNT_FULL = (FIFO_ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA      = 2'd2,
        STOP_BIT  = 2'd3
    } state_t;

    state_t                     state;
    logic [COUNTER_WIDTH-1:0]   cnt;
    logic [2:0]                 bit_idx;
    logic [7:0]                 shift;

    logic [7:0]                 mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
    logic [FIFO_ADDR_WIDTH:0]   count;

    logic push;
    logic pop;
    logic bit_end;

    // Handshake: a byte is accepted on any rising edge with write=1 and fifo_full=0;
    // there is no ready return path, so writes while full are lost.
    assign fifo_full  = (count == COUNT_FULL);
    assign fifo_empty = (count == '0);
    assign busy       = (state != IDLE);
    assign state_dbg  = state;

    assign bit_end = (cnt == CNT_MAX);
    assign push    = write && !fifo_full;
    assign pop     = !fifo_empty &&
                     ((state == IDLE) || ((state == STOP_BIT) && bit_end));

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            Tx        <= 1'b1;
            byte_sent <= 1'b0;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
        end else begin
            byte_sent <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    Tx  <= 1'b1;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        Tx    <= 1'b0;
                        state <= START_BIT;
                    end
                end
                START_BIT: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        Tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            Tx    <= 1'b1;
                            state <= STOP_BIT;
                        end else begin
                            // shift[1] is the next bit once the register moves right
                            shift   <= {1'b0, shift[7:1]};
                            Tx      <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP_BIT: begin
                    Tx <= 1'b1;
                    // registered one cycle early so the pulse lands on the final stop cycle
                    if (cnt == CNT_PRE) begin
                        byte_sent <= 1'b1;
                    end
                    if (bit_end) begin
                        cnt <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            Tx    <= 1'b0;
                            state <= START_BIT;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    Tx    <= 1'b1;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

UART transmitter with a small write-side FIFO: serialises bytes as 8N1 frames (one start bit, eight data bits LSB first, one stop bit, no parity) on `Tx`. Sits at the output end of the UART link and is the counterpart of the UART receiver. Upstream logic pushes bytes with a one-cycle write strobe. Buffered bytes go out back-to-back without idle gaps.

## Interface
Parameters:
- `CLK_PER_BIT`, 104: clock cycles per UART bit, equal to f_clock / f_baud. Minimum 2.
- `COUNTER_WIDTH`, 7: width of the bit-period counter. It must satisfy 2^COUNTER_WIDTH ≥ CLK_PER_BIT.
- `FIFO_ADDR_WIDTH`, 2: FIFO depth is 2^FIFO_ADDR_WIDTH entries, 4 by default.

Ports:
- `clock`  in  1: single clock. Everything is synchronous to its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `data`  in  8: byte to enqueue.
- `write`  in  1: enqueue strobe. `data` is sampled on the rising edge while `write`=1.
- `Tx`  out  1: serial line. Idles high.
- `busy`  out  1: high while a frame is being transmitted (state ≠ IDLE).
- `fifo_full`  out  1: FIFO holds 2^FIFO_ADDR_WIDTH bytes.
- `fifo_empty`  out  1: FIFO holds 0 bytes.
- `byte_sent`  out  1: one-cycle pulse on the last cycle of each stop bit.

## Operation
- FIFO:
  - Circular buffer with read pointer, write pointer and occupancy count (FIFO_ADDR_WIDTH+1 bits). Pointers wrap modulo depth.
  - A write with `fifo_full`=1 is dropped silently; no pointer or count change.
  - `fifo_full` is decided on the registered count. A write while full is dropped even if a pop happens in the same cycle.
  - When a push and a pop occur in the same cycle (FIFO not full), the count is unchanged and both pointers advance.
- State machine, registered:
  - IDLE: `Tx`=1. If FIFO not empty, pop the head into the shift register, clear the counter, go to START_BIT.
  - START_BIT: `Tx`=0 for CLK_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `Tx`=shift[0] for CLK_PER_BIT cycles per bit, then shift right and increment the bit index. After bit 7 completes, go to STOP_BIT.
  - STOP_BIT: `Tx`=1 for CLK_PER_BIT cycles. On the last cycle, pulse `byte_sent`. If FIFO not empty, pop and go directly to START_BIT (no gap). Otherwise go to IDLE.
  - Illegal or unused state encodings go to IDLE.
- Counter: counts 0..CLK_PER_BIT-1. It wraps to 0 at CLK_PER_BIT-1 and on every state change; bit transitions occur on that wrap. The bit index is 3 bits.
- `Tx` is a register output, so it is glitch-free.
- Reset (synchronous, any time including mid-frame):
  - state=IDLE, `Tx`=1, `busy`=0, `byte_sent`=0, `fifo_empty`=1, `fifo_full`=0.
  - Pointers, count, counter and bit index are cleared. FIFO contents are discarded.
  - An aborted frame is not resumed; the line returns high on the next cycle.
  - `write` during reset is ignored.

## Timing
- Write-to-line latency from IDLE with FIFO empty:
  - `write` sampled at edge E0.
  - `fifo_empty` falls after E0.
  - Pop occurs at E1. `Tx` falls and `busy` rises after E1.
- Frame length is exactly 10×CLK_PER_BIT cycles.
- Data bit k occupies cycles [(1+k)·CLK_PER_BIT, (2+k)·CLK_PER_BIT) relative to the start-bit edge.
- Consecutive queued frames: the next start bit begins the cycle after the previous stop bit's last cycle. Back-to-back frames are 10×CLK_PER_BIT apart.
- `byte_sent` is high exactly one cycle per frame, aligned to the stop bit's final cycle. `busy` stays high across back-to-back frames.
- `fifo_full` and `fifo_empty` update the cycle after the causing push or pop edge.

## Test plan
- Reset values: assert `reset` for 3 cycles → `Tx`=1, `busy`=0, `fifo_empty`=1, `fifo_full`=0, `byte_sent`=0.
- Single byte (CLK_PER_BIT=4), write 0xA5 → `Tx` falls 2 edges after the write.
  - Line pattern: 0, 1,0,1,0,0,1,0,1, 1, each bit held 4 cycles.
  - `byte_sent` pulses once at cycle 40 of the frame; then `busy`=0.
- Back-to-back: write 0x00, 0xFF, 0x3C in 3 consecutive cycles → three frames with no idle gap.
  - Start bits are 40 cycles apart, with 3 `byte_sent` pulses.
  - Receiver loopback recovers 0x00, 0xFF, 0x3C.
- Overflow: while 0x11 is transmitting, write 0x22,0x33,0x44,0x55,0x66 → `fifo_full`=1 after the 4th write. 0x66 is dropped; the sent sequence is 0x11,0x22,0x33,0x44,0x55.
- Simultaneous push/pop: a write in the same cycle as the stop-bit-end pop, with 1 byte queued → count stays 1, both bytes sent in order.
- Reset mid-frame: assert `reset` during data bit 3 of 0x5A with 2 bytes queued → `Tx`=1 and `fifo_empty`=1 next cycle. No further frames; a new write of 0x81 transmits correctly.
